// File: rtl/bit_scan_pkg.sv
// Shared types for the bit-scan iterator: scan FSM state encoding.
package bit_scan_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SCAN = 2'd1,
    DONE = 2'd2
  } state_e;

endpackage

// File: rtl/bit_scan_iter_ffs_encoder.sv
// Combinational find-first-set: lowest set index (msb_first=0) or highest (msb_first=1).
module ffs_encoder #(
  parameter int unsigned DATAWIDTH = 16
) (
  input  logic [DATAWIDTH-1:0]         vector,
  input  logic                         msb_first,
  output logic [$clog2(DATAWIDTH)-1:0] index,
  output logic                         any
);

  localparam int unsigned IDXW = $clog2(DATAWIDTH);

  logic found;

  // Ascending sweep: the first hit is kept for LSB-first, the last hit wins for MSB-first.
  always_comb begin
    index = '0;
    found = 1'b0;
    for (int unsigned i = 0; i < DATAWIDTH; i++) begin
      if (vector[i]) begin
        if (msb_first || !found) begin
          index = i[IDXW-1:0];
        end
        found = 1'b1;
      end
    end
    any = found;
  end

endmodule

// File: rtl/bit_scan_iter.sv
// Iterates over the set bits of a loaded vector, one index per handshake, in LSB- or MSB-first order.
module bit_scan_iter
  import bit_scan_pkg::*;
#(
  parameter int unsigned DATAWIDTH = 16
) (
  input  logic                           i_clk,
  input  logic                           i_rst,
  input  logic                           i_Valid,
  output logic                           o_Ready,
  input  logic [DATAWIDTH-1:0]           i_Sequence,
  input  logic                           i_MsbFirst,
  input  logic                           i_Abort,
  output logic [$clog2(DATAWIDTH)-1:0]   o_Index,
  output logic                           o_IndexValid,
  input  logic                           i_IndexReady,
  output logic                           o_Last,
  output logic [$clog2(DATAWIDTH):0]     o_Count,
  output logic                           o_Done
);

  localparam int unsigned IDXW = $clog2(DATAWIDTH);
  localparam int unsigned CNTW = $clog2(DATAWIDTH) + 1;
  localparam logic [DATAWIDTH-1:0] LSB_ONE = DATAWIDTH'(1);

  state_e                 state_q, state_d;
  logic [DATAWIDTH-1:0]   r_q, r_d;
  logic                   m_q, m_d;
  logic [CNTW-1:0]        cnt_q, cnt_d;

  logic [IDXW-1:0]        enc_idx;
  logic                   enc_any;
  logic                   in_scan;
  logic                   single_bit;
  logic                   handshake;

  function automatic logic [CNTW-1:0] popcount(input logic [DATAWIDTH-1:0] v);
    logic [CNTW-1:0] c;
    c = '0;
    for (int unsigned i = 0; i < DATAWIDTH; i++) begin
      c = c + CNTW'(v[i]);
    end
    return c;
  endfunction

  ffs_encoder #(
    .DATAWIDTH(DATAWIDTH)
  ) u_ffs (
    .vector   (r_q),
    .msb_first(m_q),
    .index    (enc_idx),
    .any      (enc_any)
  );

  assign in_scan    = (state_q == SCAN);
  assign single_bit = enc_any && ((r_q & (r_q - LSB_ONE)) == '0);
  assign handshake  = in_scan && i_IndexReady;

  assign o_Ready      = (state_q == IDLE);
  assign o_IndexValid = in_scan;
  assign o_Index      = in_scan ? enc_idx : '0;
  assign o_Last       = in_scan && single_bit;
  assign o_Count      = cnt_q;
  assign o_Done       = (state_q == DONE);

  always_comb begin
    state_d = state_q;
    r_d     = r_q;
    m_d     = m_q;
    cnt_d   = cnt_q;
    if (i_Abort) begin
      state_d = IDLE;
      r_d     = '0;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (i_Valid) begin
            r_d     = i_Sequence;
            m_d     = i_MsbFirst;
            cnt_d   = popcount(i_Sequence);
            state_d = (i_Sequence != '0) ? SCAN : DONE;
          end
        end
        SCAN: begin
          if (handshake) begin
            r_d = r_q & ~(LSB_ONE << enc_idx);
            if (single_bit) begin
              state_d = DONE;
            end
          end
        end
        DONE:    state_d = IDLE;
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state_q <= IDLE;
      r_q     <= '0;
      m_q     <= 1'b0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      r_q     <= r_d;
      m_q     <= m_d;
      cnt_q   <= cnt_d;
    end
  end

endmodule

// File: tb/tb_bit_scan_iter.sv
// Scoreboard bench for bit_scan_iter: stimulus pushes expected indices/done counts, a monitor pops and compares.
module tb_bit_scan_iter;

  localparam int unsigned DW = 16;

  typedef struct packed {
    logic [3:0] idx;
    logic       last;
  } exp_idx_t;

  logic          clk;
  logic          rst;
  logic          valid;
  logic          ready;
  logic [DW-1:0] seq;
  logic          msb;
  logic          abort_in;
  logic [3:0]    index;
  logic          index_valid;
  logic          index_ready;
  logic          last;
  logic [4:0]    count;
  logic          done;

  exp_idx_t   idx_q[$];
  logic [4:0] done_q[$];

  int errors = 0;
  int checks = 0;

  bit_scan_iter #(.DATAWIDTH(DW)) dut (
    .i_clk       (clk),
    .i_rst       (rst),
    .i_Valid     (valid),
    .o_Ready     (ready),
    .i_Sequence  (seq),
    .i_MsbFirst  (msb),
    .i_Abort     (abort_in),
    .o_Index     (index),
    .o_IndexValid(index_valid),
    .i_IndexReady(index_ready),
    .o_Last      (last),
    .o_Count     (count),
    .o_Done      (done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic push_idx(input logic [3:0] i, input logic l);
    exp_idx_t e;
    e.idx  = i;
    e.last = l;
    idx_q.push_back(e);
  endtask

  // Monitor: samples on the falling edge, away from the active edge.
  always @(negedge clk) begin
    exp_idx_t e;
    if (!rst) begin
      if (!index_valid) check("idx_zero_when_invalid", {28'd0, index}, 32'd0);
      if (index_valid && index_ready) begin
        if (idx_q.size() == 0) begin
          check("unexpected_index", {28'd0, index}, 32'hFFFF_FFFF);
        end else begin
          e = idx_q.pop_front();
          check("index", {28'd0, index}, {28'd0, e.idx});
          check("last", {31'd0, last}, {31'd0, e.last});
        end
      end
      if (done) begin
        if (done_q.size() == 0) begin
          check("unexpected_done", 32'd1, 32'd0);
        end else begin
          check("done_count", {27'd0, count}, {27'd0, done_q.pop_front()});
        end
      end
    end
  end

  task automatic wait_idle(input string name);
    int n;
    n = 0;
    while (!ready && n < 50) begin
      @(posedge clk); #1;
      n++;
    end
    if (!ready) check({name, "_idle_timeout"}, 32'd0, 32'd1);
  endtask

  // Presents one load; returns #1 after the accepting edge.
  task automatic load(input logic [DW-1:0] s, input logic m);
    wait_idle("load");
    valid = 1'b1;
    seq   = s;
    msb   = m;
    @(posedge clk); #1;
    valid = 1'b0;
    seq   = '0;
  endtask

  initial begin
    rst = 1'b1; valid = 1'b0; seq = '0; msb = 1'b0; abort_in = 1'b0; index_ready = 1'b1;
    #3;
    check("rst_ready", {31'd0, ready}, 32'd1);
    check("rst_ivalid", {31'd0, index_valid}, 32'd0);
    check("rst_index", {28'd0, index}, 32'd0);
    check("rst_last", {31'd0, last}, 32'd0);
    check("rst_done", {31'd0, done}, 32'd0);
    check("rst_count", {27'd0, count}, 32'd0);
    @(posedge clk); @(posedge clk); #1;
    rst = 1'b0;

    // Scenario 1: LSB-first, ready held high, no bubbles
    push_idx(4'd2, 1'b0); push_idx(4'd4, 1'b0); push_idx(4'd5, 1'b0);
    push_idx(4'd9, 1'b0); push_idx(4'd12, 1'b1);
    done_q.push_back(5'd5);
    load(16'h1234, 1'b0);
    check("s1_count", {27'd0, count}, 32'd5);
    for (int k = 0; k < 5; k++) begin
      check("s1_nobubble", {31'd0, index_valid}, 32'd1);
      @(posedge clk); #1;
    end
    check("s1_done", {31'd0, done}, 32'd1);
    @(posedge clk); #1;
    check("s1_ready_after", {31'd0, ready}, 32'd1);
    check("s1_done_cleared", {31'd0, done}, 32'd0);

    // Scenario 2: MSB-first
    push_idx(4'd12, 1'b0); push_idx(4'd9, 1'b0); push_idx(4'd5, 1'b0);
    push_idx(4'd4, 1'b0); push_idx(4'd2, 1'b1);
    done_q.push_back(5'd5);
    load(16'h1234, 1'b1);
    wait_idle("s2");

    // Scenario 3: all-zero load
    done_q.push_back(5'd0);
    load(16'h0000, 1'b0);
    check("s3_no_ivalid", {31'd0, index_valid}, 32'd0);
    check("s3_done", {31'd0, done}, 32'd1);
    check("s3_count", {27'd0, count}, 32'd0);
    @(posedge clk); #1;
    check("s3_ready", {31'd0, ready}, 32'd1);

    // Scenario 4: consumer stalls for 3 cycles
    index_ready = 1'b0;
    push_idx(4'd0, 1'b0); push_idx(4'd15, 1'b1);
    done_q.push_back(5'd2);
    load(16'h8001, 1'b0);
    for (int k = 0; k < 3; k++) begin
      check("s4_hold_valid", {31'd0, index_valid}, 32'd1);
      check("s4_hold_index", {28'd0, index}, 32'd0);
      check("s4_hold_last", {31'd0, last}, 32'd0);
      if (k < 2) begin
        @(posedge clk); #1;
      end
    end
    index_ready = 1'b1;
    wait_idle("s4");

    // Scenario 5: abort after 3 handshakes; then a fresh load
    push_idx(4'd0, 1'b0); push_idx(4'd1, 1'b0); push_idx(4'd2, 1'b0);
    load(16'hFFFF, 1'b0);
    check("s5_count", {27'd0, count}, 32'd16);
    repeat (3) begin
      @(posedge clk); #1;
    end
    index_ready = 1'b0;
    abort_in    = 1'b1;
    @(posedge clk); #1;
    abort_in    = 1'b0;
    index_ready = 1'b1;
    check("s5_ready", {31'd0, ready}, 32'd1);
    check("s5_ivalid", {31'd0, index_valid}, 32'd0);
    check("s5_no_done", {31'd0, done}, 32'd0);
    @(posedge clk); #1;
    check("s5_no_done_later", {31'd0, done}, 32'd0);
    push_idx(4'd8, 1'b1);
    done_q.push_back(5'd1);
    load(16'h0100, 1'b0);
    check("s5_new_index", {28'd0, index}, 32'd8);
    wait_idle("s5");

    // Scenario 6: asynchronous reset mid-scan
    push_idx(4'd4, 1'b0); push_idx(4'd5, 1'b0);
    load(16'hFFF0, 1'b0);
    @(posedge clk); #1;
    @(posedge clk); #2;
    rst = 1'b1;
    #1;
    check("s6_ready", {31'd0, ready}, 32'd1);
    check("s6_ivalid", {31'd0, index_valid}, 32'd0);
    check("s6_index", {28'd0, index}, 32'd0);
    check("s6_last", {31'd0, last}, 32'd0);
    check("s6_done", {31'd0, done}, 32'd0);
    check("s6_count", {27'd0, count}, 32'd0);
    @(posedge clk); #1;
    check("s6_done_held", {31'd0, done}, 32'd0);
    // First edge after reset release accepts a load
    rst   = 1'b0;
    valid = 1'b1;
    seq   = 16'h0100;
    msb   = 1'b0;
    push_idx(4'd8, 1'b1);
    done_q.push_back(5'd1);
    @(posedge clk); #1;
    valid = 1'b0;
    seq   = '0;
    check("s6_first_load", {31'd0, index_valid}, 32'd1);
    wait_idle("s6");
    @(posedge clk); #1;

    check("idx_queue_empty", idx_q.size(), 32'd0);
    check("done_queue_empty", done_q.size(), 32'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/bit_scan_iter.md
BIT_SCAN_ITER -- requirements
Module: bit_scan_iter

Interface
REQ-001 Parameter DATAWIDTH, default 16, SHALL set the scanned vector width; legal range is 2..256.
REQ-002 Localparam IDXW SHALL equal $clog2(DATAWIDTH) and localparam CNTW SHALL equal $clog2(DATAWIDTH)+1.
REQ-003 Port i_clk, input, width 1: the single clock; all state is rising-edge.
REQ-004 Port i_rst, input, width 1: reset, asynchronous, active-high.
REQ-005 Port i_Valid, input, width 1: load request.
REQ-006 Port o_Ready, output, width 1: block can accept a load.
REQ-007 Port i_Sequence, input, width DATAWIDTH: vector to scan, sampled on load.
REQ-008 Port i_MsbFirst, input, width 1: scan order, sampled on load (0 = LSB-first, 1 = MSB-first).
REQ-009 Port i_Abort, input, width 1: cancel the current scan.
REQ-010 Port o_Index, output, width IDXW: index of the current set bit.
REQ-011 Port o_IndexValid, output, width 1: o_Index is valid.
REQ-012 Port i_IndexReady, input, width 1: consumer accepts o_Index.
REQ-013 Port o_Last, output, width 1: the current index is the final set bit.
REQ-014 Port o_Count, output, width CNTW: popcount of the last loaded vector.
REQ-015 Port o_Done, output, width 1: one-cycle scan-complete pulse.

Function
REQ-016 The FSM SHALL have exactly three states: IDLE, SCAN and DONE.
REQ-017 o_Ready SHALL be 1 only in IDLE; a load occurs when i_Valid && o_Ready at a clock edge.
REQ-018 On load, the block SHALL register i_Sequence into residual register R, i_MsbFirst into mode M, and popcount(i_Sequence) into o_Count.
REQ-019 On load, the FSM SHALL go to SCAN if i_Sequence != 0, otherwise to DONE.
REQ-020 In SCAN, o_IndexValid SHALL be 1 and o_Index SHALL be the lowest set-bit index of R when M=0, or the highest when M=1; the first index is visible one cycle after load.
REQ-021 On an output handshake (o_IndexValid && i_IndexReady), bit o_Index of R SHALL be cleared at that edge, so the next index appears the following cycle.
REQ-022 Sustained i_IndexReady=1 SHALL yield one index per cycle, with no bubbles.
REQ-023 o_Last SHALL be 1 in SCAN exactly when R has one set bit.
REQ-024 A handshake while o_Last=1 SHALL move the FSM to DONE.
REQ-025 With i_IndexReady=0, o_Index, o_IndexValid and o_Last SHALL hold stable.
REQ-026 DONE SHALL last exactly one cycle with o_Done=1, then return to IDLE; o_Done SHALL be 0 in all other states.
REQ-027 An all-zero load SHALL produce no o_IndexValid and SHALL give o_Done=1 in the cycle after load, with o_Count=0.
REQ-028 i_Abort=1 SHALL have highest priority: from any state, the next state is IDLE, R is cleared and no o_Done is produced; an abort coincident with a handshake SHALL discard that handshake.
REQ-029 o_Index SHALL be 0 whenever o_IndexValid=0.
REQ-030 o_Count SHALL hold its value until the next load.
REQ-031 i_Valid outside IDLE SHALL be ignored; no queuing.
REQ-032 DATAWIDTH=256 with all bits set SHALL give o_Count=256 without overflow.

Reset
REQ-033 While i_rst=1, the state SHALL be IDLE, R=0, M=0 and o_Count=0, giving o_Ready=1, o_IndexValid=0, o_Index=0, o_Last=0 and o_Done=0.
REQ-034 Reset asserted mid-scan SHALL take effect immediately, without waiting for a clock edge, with no o_Done.
REQ-035 The first load SHALL be accepted at the first edge after i_rst deasserts.

Structure
REQ-036 Package bit_scan_pkg SHALL hold the state enum typedef (IDLE, SCAN, DONE).
REQ-037 Sub-module ffs_encoder (parameter DATAWIDTH; inputs vector and msb_first; outputs index and any) SHALL provide the combinational first-set-bit search.
REQ-038 The popcount and the FSM SHALL live in bit_scan_iter.

Verification
REQ-039 Scenario 1: load 16'h1234 with M=0 and ready held 1 -> indices 2, 4, 5, 9, 12 on consecutive cycles, o_Last on 12, o_Count=5, o_Done one cycle after 12.
REQ-040 Scenario 2: load 16'h1234 with M=1 -> indices 12, 9, 5, 4, 2; o_Last on 2.
REQ-041 Scenario 3: load 16'h0000 -> o_IndexValid never asserts, o_Count=0, o_Done=1 the next cycle, o_Ready=1 the cycle after.
REQ-042 Scenario 4: load 16'h8001 with M=0 and i_IndexReady low for 3 cycles -> o_Index=0 held stable for 3 cycles, then 0 and 15 on the next two handshakes.
REQ-043 Scenario 5: load 16'hFFFF, abort after 3 handshakes -> IDLE next cycle, no o_Done, o_Ready=1; a new load of 16'h0100 gives index 8.
REQ-044 Scenario 6: assert i_rst asynchronously mid-scan of 16'hFFF0 -> outputs take their reset values immediately; o_Done does not pulse.
